// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - serializes 4-sample complex words onto DR/DI with a one-word holding buffer
module parallel_to_serial #(
  parameter int nb = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            LOAD,
  input  logic [4*nb-1:0] IR,
  input  logic [4*nb-1:0] II,
  output logic            IN_RDY,
  output logic [nb-1:0]   DR,
  output logic [nb-1:0]   DI,
  output logic            VLD,
  output logic            FIRST
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic              hold_full;
  logic [4*nb-1:0]   hold_r, hold_i;
  logic [4*nb-1:0]   shr_r, shr_i;
  logic [4*nb-1:0]   src_r, src_i;
  logic              accept;
  logic              word_end;
  logic              start_word;

  assign IN_RDY   = ~hold_full;
  assign accept   = LOAD & ~hold_full;
  assign word_end = (state == IDLE) || (cnt == 2'd3);
  // In IDLE hold_full is always 0, so one mux serves both the idle and the end-of-word start.
  assign start_word = word_end && (hold_full || LOAD);
  assign src_r      = hold_full ? hold_r : IR;
  assign src_i      = hold_full ? hold_i : II;

  always_ff @(posedge CLK) begin
    if (state == SHIFT && cnt != 2'd3 && accept) begin
      hold_r <= IR;
      hold_i <= II;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      hold_full <= 1'b0;
      DR        <= '0;
      DI        <= '0;
      VLD       <= 1'b0;
      FIRST     <= 1'b0;
      shr_r     <= '0;
      shr_i     <= '0;
    end else if (start_word) begin
      state     <= SHIFT;
      cnt       <= 2'd0;
      hold_full <= 1'b0;
      VLD       <= 1'b1;
      FIRST     <= 1'b1;
      DR        <= src_r[4*nb-1 -: nb];
      DI        <= src_i[4*nb-1 -: nb];
      shr_r     <= {src_r[3*nb-1:0], {nb{1'b0}}};
      shr_i     <= {src_i[3*nb-1:0], {nb{1'b0}}};
    end else if (state == SHIFT && cnt != 2'd3) begin
      cnt   <= cnt + 2'd1;
      FIRST <= 1'b0;
      DR    <= shr_r[4*nb-1 -: nb];
      DI    <= shr_i[4*nb-1 -: nb];
      shr_r <= {shr_r[3*nb-1:0], {nb{1'b0}}};
      shr_i <= {shr_i[3*nb-1:0], {nb{1'b0}}};
      if (accept) begin
        hold_full <= 1'b1;
      end
    end else begin
      state <= IDLE;
      cnt   <= 2'd0;
      VLD   <= 1'b0;
      FIRST <= 1'b0;
      DR    <= '0;
      DI    <= '0;
    end
  end

endmodule
